mem_write_checker: RTL

- Synthesizable self-check stage directly downstream of the pipelined MIPS top level.
- Consumes the data-memory store bus (memwrite, dataadr, writedata) every cycle.
- Compares each store against an in-order queue of expected stores, loaded by the bench or a ROM.
- Detects a terminator store and reports PASS/FAIL, mismatch details and a hang timeout, so benches stop hard-coding the address-8 check.

---
 rtl/mem_write_checker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/mem_write_checker.sv
// Store-bus self-check: matches data-memory stores against an expected queue.
// Define MEMCHK_CONTINUE_EN to keep running past data/address mismatches.
module mem_write_checker #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] TERM_ADDR = 32'h00000008,
  parameter logic [31:0] TERM_DATA = 32'h04ee9112,
  parameter int          TIMEOUT   = 1024,
  parameter int          CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [31:0]   dataadr,
  input  logic [31:0]   writedata,
  input  logic          exp_valid,
  input  logic [31:0]   exp_addr,
  input  logic [31:0]   exp_data,
  output logic          exp_ready,
  output logic          done,
  output logic          pass,
  output logic          fail,
  output logic [2:0]    fail_code,
  output logic [31:0]   bad_addr,
  output logic [31:0]   bad_data,
  output logic [CW-1:0] err_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    RUN,
    PASS,
    FAIL
  } state_t;

  state_t        state;
  logic [31:0]   qa [DEPTH];
  logic [31:0]   qd [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic [CW-1:0] timer;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic store;
  logic is_term;
  logic head_hit;
  logic tmo;
  logic first;

  assign full     = cnt == (AW+1)'(DEPTH);
  assign empty    = cnt == '0;
  assign push     = exp_valid && !full;
  assign store    = (state == RUN) && memwrite;
  assign is_term  = (dataadr == TERM_ADDR) && (writedata == TERM_DATA);
  assign head_hit = (qa[rp] == dataadr) && (qd[rp] == writedata);
  // a queued terminator is consumed like any other expected store
  assign pop      = store && !empty && (!is_term || head_hit);
  assign tmo      = (state == RUN) && !memwrite
                 && (timer == CW'(TIMEOUT - 1));
  assign first    = err_count == '0;

  assign exp_ready = !full;
  assign done      = state != RUN;
  assign pass      = state == PASS;
  assign fail      = state == FAIL;

  always_ff @(posedge clk) begin
    if (push) begin
      qa[wp] <= exp_addr;
      qd[wp] <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      timer     <= '0;
      fail_code <= 3'd0;
      bad_addr  <= '0;
      bad_data  <= '0;
      err_count <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};
      if (state == RUN) begin
        if (memwrite)
          timer <= '0;
        else if (!tmo)
          timer <= timer + 1'b1;
      end
      if (store) begin
        if (is_term && empty) begin
`ifdef MEMCHK_CONTINUE_EN
          if (first) begin
            state <= PASS;
          end else begin
            state     <= FAIL;
            fail_code <= 3'd1;
          end
`else
          state <= PASS;
`endif
        end else if (is_term && !head_hit) begin
          state     <= FAIL;
          fail_code <= 3'd3;
          if (first) begin
            bad_addr <= dataadr;
            bad_data <= writedata;
          end
        end else if (empty) begin
          state     <= FAIL;
          fail_code <= 3'd2;
          if (first) begin
            bad_addr <= dataadr;
            bad_data <= writedata;
          end
        end else if (!head_hit) begin
          if (err_count != '1)
            err_count <= err_count + 1'b1;
          if (first) begin
            bad_addr <= dataadr;
            bad_data <= writedata;
          end
`ifndef MEMCHK_CONTINUE_EN
          state     <= FAIL;
          fail_code <= 3'd1;
`endif
        end
      end else if (tmo) begin
        state     <= FAIL;
        fail_code <= 3'd4;
      end
    end
  end

endmodule
